serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl.sv | 125 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full adder is reused for every bit, LSB first, over WIDTH clocks.
// Optional subtract mode when SERIAL_ADD_CTRL_SUB_EN is defined (adds the 'sub' input).

module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADD_CTRL_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_reg, state_next;
   logic [WIDTH-1:0]   a_sh_reg, a_sh_next;
   logic [WIDTH-1:0]   b_sh_reg, b_sh_next;
   logic               carry_reg, carry_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [WIDTH-1:0]   sum_reg, sum_next;
   logic               cout_reg, cout_next;
   logic               fa_s, fa_co;
   logic [WIDTH-1:0]   b_load;
   logic               carry_load;

`ifdef SERIAL_ADD_CTRL_SUB_EN
   // a - b computed as a + ~b + 1; cout=1 then means no borrow
   assign b_load     = sub ? ~b : b;
   assign carry_load = sub ? 1'b1 : cin;
`else
   assign b_load     = b;
   assign carry_load = cin;
`endif

   full_adder u_fa (
      .a    (a_sh_reg[0]),
      .b    (b_sh_reg[0]),
      .cin  (carry_reg),
      .s    (fa_s),
      .cout (fa_co)
   );

   always_comb begin
      state_next = state_reg;
      a_sh_next  = a_sh_reg;
      b_sh_next  = b_sh_reg;
      carry_next = carry_reg;
      cnt_next   = cnt_reg;
      sum_next   = sum_reg;
      cout_next  = cout_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               a_sh_next  = a;
               b_sh_next  = b_load;
               carry_next = carry_load;
               cnt_next   = '0;
               state_next = RUN;
            end
         end
         RUN: begin
            // Result bits fill the MSBs vacated by operand A, so A's register doubles as the partial result
            a_sh_next  = {fa_s, a_sh_reg[WIDTH-1:1]};
            b_sh_next  = {1'b0, b_sh_reg[WIDTH-1:1]};
            carry_next = fa_co;
            cnt_next   = cnt_reg + CNT_W'(1);
            if (cnt_reg == LAST) begin
               sum_next   = {fa_s, a_sh_reg[WIDTH-1:1]};
               cout_next  = fa_co;
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         a_sh_reg  <= '0;
         b_sh_reg  <= '0;
         carry_reg <= 1'b0;
         cnt_reg   <= '0;
         sum_reg   <= '0;
         cout_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         a_sh_reg  <= a_sh_next;
         b_sh_reg  <= b_sh_next;
         carry_reg <= carry_next;
         cnt_reg   <= cnt_next;
         sum_reg   <= sum_next;
         cout_reg  <= cout_next;
      end
   end

   assign busy = (state_reg == RUN);
   assign done = (state_reg == DONE);
   assign sum  = sum_reg;
   assign cout = cout_reg;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8; subtract cases build only with SERIAL_ADD_CTRL_SUB_EN.

module tb_serial_add_ctrl;
   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             cin = 1'b0;
`ifdef SERIAL_ADD_CTRL_SUB_EN
   logic             sub = 1'b0;
`endif
   logic             busy, done, cout;
   logic [WIDTH-1:0] sum;

   int checks = 0;
   int errors = 0;

   serial_add_ctrl #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
`ifdef SERIAL_ADD_CTRL_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   always #5 clk = ~clk;

   // Request one operation; returns at the negedge just after the accepting edge
   task automatic start_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv);
      @(negedge clk);
      a = av; b = bv; cin = cv; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (done) seen = 1'b1;
         else @(negedge clk);
      end
   endtask

   task automatic test_reset;
      #2;
      checks++;
      if ({busy, done, cout, sum} !== {1'b0, 1'b0, 1'b0, 8'h00}) begin
         errors++;
         $display("FAIL reset: busy=%b done=%b cout=%b sum=%h, required 0 0 0 00", busy, done, cout, sum);
      end
      @(negedge clk);
      rst_n = 1'b1;
      $display("reset released: busy=%b done=%b sum=%h cout=%b", busy, done, sum, cout);
   endtask

   task automatic test_basic;
      start_op(8'h35, 8'h4A, 1'b0);
      for (int i = 0; i < WIDTH; i++) begin
         checks++;
         if (busy !== 1'b1 || done !== 1'b0 || sum !== 8'h00) begin
            errors++;
            $display("FAIL basic_run%0d: busy=%b done=%b sum=%h, required 1 0 00", i, busy, done, sum);
         end
         @(negedge clk);
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || sum !== 8'h7F || cout !== 1'b0) begin
         errors++;
         $display("FAIL basic_done: done=%b busy=%b sum=%h cout=%b, required 1 0 7f 0", done, busy, sum, cout);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || sum !== 8'h7F) begin
         errors++;
         $display("FAIL basic_after: done=%b busy=%b sum=%h, required 0 0 7f", done, busy, sum);
      end
      $display("basic 35+4A+0: sum=%h cout=%b", sum, cout);
   endtask

   task automatic test_carry;
      bit seen;
      start_op(8'hFF, 8'h01, 1'b0);
      wait_done(seen);
      checks++;
      if (!seen || sum !== 8'h00 || cout !== 1'b1) begin
         errors++;
         $display("FAIL carry: seen=%b sum=%h cout=%b, required 1 00 1", seen, sum, cout);
      end
      $display("carry FF+01+0: sum=%h cout=%b", sum, cout);
   endtask

   task automatic test_hold_inputs;
      bit seen;
      start_op(8'hFF, 8'hFF, 1'b1);
      a = 8'h00; b = 8'h00; cin = 1'b0;
      wait_done(seen);
      checks++;
      if (!seen || sum !== 8'hFF || cout !== 1'b1) begin
         errors++;
         $display("FAIL hold_inputs: seen=%b sum=%h cout=%b, required 1 ff 1", seen, sum, cout);
      end
      $display("hold FF+FF+1 (inputs zeroed): sum=%h cout=%b", sum, cout);
   endtask

   task automatic test_ignore_start;
      int pulses = 0;
      bit seen;
      logic [WIDTH-1:0] s_at_pulse = '0;
      start_op(8'h01, 8'h01, 1'b0);
      a = 8'h10; b = 8'h10; start = 1'b1;
      for (int i = 0; i < 24; i++) begin
         if (i == 4) start = 1'b0;
         if (done) begin
            pulses++;
            s_at_pulse = sum;
         end
         @(negedge clk);
      end
      checks++;
      if (pulses != 1 || s_at_pulse !== 8'h02 || busy !== 1'b0) begin
         errors++;
         $display("FAIL ignore_start: pulses=%0d sum=%h busy=%b, required 1 02 0", pulses, s_at_pulse, busy);
      end
      start_op(8'h10, 8'h10, 1'b0);
      wait_done(seen);
      checks++;
      if (!seen || sum !== 8'h20 || cout !== 1'b0) begin
         errors++;
         $display("FAIL restart: seen=%b sum=%h cout=%b, required 1 20 0", seen, sum, cout);
      end
      $display("ignore_start: pulses=%0d, then 10+10 sum=%h", pulses, sum);
   endtask

   task automatic test_back_to_back;
      bit seen;
      start_op(8'h12, 8'h34, 1'b0);
      wait_done(seen);
      checks++;
      if (!seen || sum !== 8'h46 || cout !== 1'b0) begin
         errors++;
         $display("FAIL b2b_first: seen=%b sum=%h cout=%b, required 1 46 0", seen, sum, cout);
      end
      // start raised during DONE must be ignored; the following IDLE edge accepts it
      a = 8'h80; b = 8'h80; cin = 1'b1; start = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_done_start: busy=%b, required 0", busy);
      end
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_accept: busy=%b, required 1", busy);
      end
      wait_done(seen);
      checks++;
      if (!seen || sum !== 8'h01 || cout !== 1'b1) begin
         errors++;
         $display("FAIL b2b_second: seen=%b sum=%h cout=%b, required 1 01 1", seen, sum, cout);
      end
      $display("back_to_back 12+34 then 80+80+1: sum=%h cout=%b", sum, cout);
   endtask

   task automatic test_reset_mid;
      int pulses = 0;
      bit seen;
      start_op(8'hAA, 8'h55, 1'b0);
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, cout, sum} !== {1'b0, 1'b0, 1'b0, 8'h00}) begin
         errors++;
         $display("FAIL reset_mid: busy=%b done=%b cout=%b sum=%h, required 0 0 0 00", busy, done, cout, sum);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 15; i++) begin
         if (done || busy) pulses++;
         @(negedge clk);
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL reset_abandon: active cycles=%0d, required 0", pulses);
      end
      start_op(8'h0F, 8'h01, 1'b0);
      wait_done(seen);
      checks++;
      if (!seen || sum !== 8'h10 || cout !== 1'b0) begin
         errors++;
         $display("FAIL after_reset: seen=%b sum=%h cout=%b, required 1 10 0", seen, sum, cout);
      end
      $display("reset_mid then 0F+01: sum=%h cout=%b", sum, cout);
   endtask

`ifdef SERIAL_ADD_CTRL_SUB_EN
   task automatic test_sub;
      bit seen;
      sub = 1'b1;
      start_op(8'h10, 8'h01, 1'b0);
      sub = 1'b0;
      wait_done(seen);
      checks++;
      if (!seen || sum !== 8'h0F || cout !== 1'b1) begin
         errors++;
         $display("FAIL sub1: seen=%b sum=%h cout=%b, required 1 0f 1", seen, sum, cout);
      end
      $display("sub 10-01: sum=%h cout=%b", sum, cout);
      sub = 1'b1;
      start_op(8'h01, 8'h02, 1'b0);
      sub = 1'b0;
      wait_done(seen);
      checks++;
      if (!seen || sum !== 8'hFF || cout !== 1'b0) begin
         errors++;
         $display("FAIL sub2: seen=%b sum=%h cout=%b, required 1 ff 0", seen, sum, cout);
      end
      $display("sub 01-02: sum=%h cout=%b", sum, cout);
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_carry();
      test_hold_inputs();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
`ifdef SERIAL_ADD_CTRL_SUB_EN
      test_sub();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
